mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: load/store and instruction fetch share one RAM port.
// Load/store normally wins; a fairness counter lets a starved fetch through
// after FAIR_MAX consecutive load/store grants. Each access waits up to
// TIMEOUT cycles for mem_moc and otherwise aborts with an err pulse.
module mem_arbiter #(
   parameter int TIMEOUT  = 15,
   parameter int FAIR_MAX = 4
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   input  logic        ls_req,
   input  logic        ls_rw,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   input  logic [1:0]  ls_type,
   input  logic        ls_sign,
   input  logic        mem_moc,
   input  logic [31:0] mem_rdata,
   output logic        mem_mov,
   output logic        mem_rw,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [1:0]  mem_type,
   output logic        mem_sign,
   output logic        if_done,
   output logic        ls_done,
   output logic [31:0] rdata,
   output logic        err
);

   localparam int FW = $clog2(FAIR_MAX + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE, ABORT} state_t;

   state_t          state;
   logic [FW-1:0]   fair_cnt;
   logic [WW-1:0]   wait_cnt;
   logic            owner_if;
   logic            grant_if;

   // Fetch wins only when load/store is absent or the fetch has been starved.
   assign grant_if = if_req && (!ls_req || (fair_cnt == FW'(FAIR_MAX)));

   // Main FSM; all outputs are registered so done/err line up with DONE/ABORT.
   always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
         state     <= IDLE;
         mem_mov   <= 1'b0;
         mem_rw    <= 1'b1;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_type  <= '0;
         mem_sign  <= 1'b0;
         if_done   <= 1'b0;
         ls_done   <= 1'b0;
         err       <= 1'b0;
         rdata     <= '0;
         fair_cnt  <= '0;
         wait_cnt  <= '0;
         owner_if  <= 1'b0;
      end else begin
         if_done <= 1'b0;
         ls_done <= 1'b0;
         err     <= 1'b0;
         case (state)
            IDLE: begin
               if (if_req || ls_req) begin
                  state    <= ACCESS;
                  mem_mov  <= 1'b1;
                  wait_cnt <= '0;
                  owner_if <= grant_if;
                  if (grant_if) begin
                     // Fetches are always word reads; store data is left as is.
                     mem_addr <= if_addr;
                     mem_rw   <= 1'b1;
                     mem_type <= 2'b10;
                     mem_sign <= 1'b0;
                     fair_cnt <= '0;
                  end else begin
                     mem_addr  <= ls_addr;
                     mem_rw    <= ls_rw;
                     mem_wdata <= ls_wdata;
                     mem_type  <= ls_type;
                     mem_sign  <= ls_sign;
                     // Only grants that made a fetch wait count toward fairness.
                     if (if_req && (fair_cnt != FW'(FAIR_MAX)))
                        fair_cnt <= fair_cnt + 1'b1;
                  end
               end
            end
            ACCESS: begin
               wait_cnt <= wait_cnt + 1'b1;
               // moc takes precedence over a coincident timeout.
               if (mem_moc) begin
                  if (mem_rw)
                     rdata <= mem_rdata;
                  state   <= DONE;
                  mem_mov <= 1'b0;
                  if_done <= owner_if;
                  ls_done <= !owner_if;
               end else if (wait_cnt == WW'(TIMEOUT - 1)) begin
                  state   <= ABORT;
                  mem_mov <= 1'b0;
                  if_done <= owner_if;
                  ls_done <= !owner_if;
                  err     <= 1'b1;
               end
            end
            DONE:    state <= IDLE;
            ABORT:   state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter with a transaction-level reference model.
module tb_mem_arbiter;
   localparam int TIMEOUT  = 15;
   localparam int FAIR_MAX = 4;

   logic        clk = 1'b0;
   logic        clr;
   logic        if_req, ls_req, ls_rw, ls_sign, mem_moc;
   logic [31:0] if_addr, ls_addr, ls_wdata, mem_rdata;
   logic [1:0]  ls_type;
   logic        mem_mov, mem_rw, mem_sign, if_done, ls_done, err;
   logic [31:0] mem_addr, mem_wdata, rdata;
   logic [1:0]  mem_type;

   mem_arbiter #(.TIMEOUT(TIMEOUT), .FAIR_MAX(FAIR_MAX)) dut (
      .clk(clk), .clr(clr),
      .if_req(if_req), .if_addr(if_addr),
      .ls_req(ls_req), .ls_rw(ls_rw), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
      .ls_type(ls_type), .ls_sign(ls_sign),
      .mem_moc(mem_moc), .mem_rdata(mem_rdata),
      .mem_mov(mem_mov), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_type(mem_type), .mem_sign(mem_sign),
      .if_done(if_done), .ls_done(ls_done), .rdata(rdata), .err(err)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model state
   int          fair;
   logic [31:0] exp_rdata, exp_addr, exp_wdata;
   logic        exp_rw, exp_sign;
   logic [1:0]  exp_type;
   string       grants;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic new_ls();
      ls_req   = 1'b1;
      ls_rw    = 1'($urandom);
      ls_addr  = $urandom;
      ls_wdata = $urandom;
      ls_type  = 2'($urandom);
      ls_sign  = 1'($urandom);
   endtask

   task automatic new_if();
      if_req  = 1'b1;
      if_addr = $urandom;
   endtask

   // Called at a falling edge in IDLE with requests set. moc arrives in ACCESS
   // cycle d (d > TIMEOUT means never). drop releases the owner's request early.
   task automatic run_access(input int d, input bit drop);
      bit w_if;
      int len;
      chk("idle_out", {28'd0, mem_mov, if_done, ls_done, err}, 32'd0);
      w_if = if_req && (!ls_req || fair == FAIR_MAX);
      grants = {grants, w_if ? "I" : "L"};
      if (w_if) begin
         exp_addr = if_addr; exp_rw = 1'b1; exp_type = 2'b10; exp_sign = 1'b0;
         fair = 0;
      end else begin
         exp_addr = ls_addr; exp_rw = ls_rw; exp_wdata = ls_wdata;
         exp_type = ls_type; exp_sign = ls_sign;
         if (if_req && fair < FAIR_MAX) fair++;
      end
      len = (d <= TIMEOUT) ? d : TIMEOUT;
      for (int k = 1; k <= len; k++) begin
         @(negedge clk);
         chk("acc_mov", {31'd0, mem_mov}, 32'd1);
         chk("acc_addr", mem_addr, exp_addr);
         chk("acc_ctl", {28'd0, mem_rw, mem_type, mem_sign}, {28'd0, exp_rw, exp_type, exp_sign});
         if (!w_if) chk("acc_wdata", mem_wdata, exp_wdata);
         chk("acc_pulses", {29'd0, if_done, ls_done, err}, 32'd0);
         mem_moc   = (k == d);
         mem_rdata = $urandom;
         if (k == d && exp_rw) exp_rdata = mem_rdata;
         if (drop && k == 1) begin
            if (w_if) if_req = 1'b0; else ls_req = 1'b0;
         end
      end
      @(negedge clk);
      chk("end_mov", {31'd0, mem_mov}, 32'd0);
      chk("if_done", {31'd0, if_done}, {31'd0, w_if});
      chk("ls_done", {31'd0, ls_done}, {31'd0, !w_if});
      chk("err", {31'd0, err}, {31'd0, d > TIMEOUT});
      chk("rdata", rdata, exp_rdata);
      mem_moc   = 1'($urandom);   // must be ignored outside ACCESS
      mem_rdata = $urandom;
      if (w_if) if_req = 1'b0; else ls_req = 1'b0;
      @(negedge clk);
      mem_moc = 1'b0;
      chk("hold_addr", mem_addr, exp_addr);
      chk("hold_rdata", rdata, exp_rdata);
   endtask

   function automatic int pick_delay();
      case ($urandom % 4)
         0:       return 1;
         1:       return int'($urandom_range(2, TIMEOUT - 1));
         2:       return TIMEOUT;
         default: return TIMEOUT + int'($urandom_range(1, 3));
      endcase
   endfunction

   initial begin
      clr = 1'b0; if_req = 0; ls_req = 0; ls_rw = 0; ls_sign = 0; mem_moc = 0;
      if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_type = 0; mem_rdata = 0;
      fair = 0; exp_rdata = 0; exp_addr = 0; exp_wdata = 0;
      exp_rw = 1; exp_type = 0; exp_sign = 0; grants = "";
      #12;
      chk("rst_pulses", {28'd0, mem_mov, if_done, ls_done, err}, 32'd0);
      chk("rst_ctl", {28'd0, mem_rw, mem_type, mem_sign}, 32'h8);
      chk("rst_addr", mem_addr, 32'd0);
      chk("rst_wdata", mem_wdata, 32'd0);
      chk("rst_rdata", rdata, 32'd0);
      @(negedge clk);
      clr = 1'b1;

      // single fetch, moc in 2nd ACCESS cycle
      if_req = 1'b1; if_addr = 32'h40;
      run_access(2, 1'b0);
      // store byte
      ls_req = 1'b1; ls_rw = 1'b0; ls_type = 2'b00; ls_addr = 32'h103;
      ls_wdata = 32'hFF; ls_sign = 1'b0;
      run_access(3, 1'b0);
      // write timeout
      ls_req = 1'b1; ls_rw = 1'b0; ls_addr = $urandom; ls_wdata = $urandom;
      run_access(TIMEOUT + 1, 1'b0);
      // read with moc on the timeout cycle
      ls_req = 1'b1; ls_rw = 1'b1; ls_addr = $urandom;
      run_access(TIMEOUT, 1'b0);

      // continuous contention: expect LLLLILLLLI
      grants = "";
      for (int n = 0; n < 10; n++) begin
         if (!if_req) new_if();
         if (!ls_req) new_ls();
         run_access(1, 1'b0);
      end
      checks++;
      if (grants != "LLLLILLLLI") begin
         errors++;
         $display("FAIL grant_order got=%s exp=LLLLILLLLI", grants);
      end

      // random traffic
      for (int n = 0; n < 80; n++) begin
         if (!if_req && ($urandom % 2)) new_if();
         if (!ls_req && ($urandom % 2)) new_ls();
         if (!if_req && !ls_req) begin
            mem_moc = 1'($urandom);
            @(negedge clk);
            mem_moc = 1'b0;
            chk("gap_out", {28'd0, mem_mov, if_done, ls_done, err}, 32'd0);
            chk("gap_rdata", rdata, exp_rdata);
         end else begin
            run_access(pick_delay(), ($urandom % 4) == 0);
         end
      end
      while (if_req || ls_req) run_access(1, 1'b0);

      // reset during ACCESS cycle 3
      if_req = 1'b1; if_addr = $urandom;
      @(negedge clk); @(negedge clk); @(negedge clk);
      clr = 1'b0;
      #1;
      chk("arst_pulses", {28'd0, mem_mov, if_done, ls_done, err}, 32'd0);
      chk("arst_ctl", {28'd0, mem_rw, mem_type, mem_sign}, 32'h8);
      chk("arst_addr", mem_addr, 32'd0);
      chk("arst_rdata", rdata, 32'd0);
      fair = 0; exp_rdata = 0; exp_addr = 0; exp_wdata = 0;
      @(negedge clk);
      chk("arst_hold", {28'd0, mem_mov, if_done, ls_done, err}, 32'd0);
      clr = 1'b1;
      if_addr = 32'h200;
      run_access(1, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // hard bound so the run always terminates
   initial begin
      #200000;
      $display("FAIL timeout_guard got=running exp=finished");
      $fatal(1);
   end
endmodule
